tcdm_port_cut: RTL and testbench
================================

Name: tcdm_port_cut

Overview:
- Parametrised multi-port elastic request cut placed between TCDM masters and `tcdm_interconnect` (or between the interconnect and banks).
- Per port: a request FIFO decouples the master grant from the bank grant, which breaks the combinational `gnt`-on-`req`/`add` path.
- Per port: a fixed-latency response shift register realigns `vld`/`rdata` to the bank read latency.
- Optional fall-through mode and write-response generation extend the single-cycle, always-combinational port behaviour of the current interconnect wrappers.

Parameters:
- NumPorts, 4, number of independent master/slave channel pairs (≥1)
- AddrWidth, 32, request address width
- DataWidth, 32, data width; byte-enable width is DataWidth/8
- Depth, 2, request FIFO entries per port (≥1)
- MemLatency, 1, cycles from slave grant to valid `rdata_i` (≥1)
- WriteRespEn, 0, 1: `vld_o` also pulses for stores
- FallThrough, 0, 1: an empty FIFO forwards the request combinationally in the same cycle

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous reset, active-high
- req_i  in  NumPorts  master request
- add_i  in  NumPorts×AddrWidth  address
- wen_i  in  NumPorts  1 store, 0 load
- wdata_i  in  NumPorts×DataWidth  write data
- be_i  in  NumPorts×DataWidth/8  byte enable
- gnt_o  out  NumPorts  master grant
- vld_o  out  NumPorts  response valid
- rdata_o  out  NumPorts×DataWidth  response data
- req_o  out  NumPorts  slave request
- gnt_i  in  NumPorts  slave grant
- add_o  out  NumPorts×AddrWidth  slave address
- wen_o  out  NumPorts  slave store flag
- wdata_o  out  NumPorts×DataWidth  slave write data
- be_o  out  NumPorts×DataWidth/8  slave byte enable
- rdata_i  in  NumPorts×DataWidth  slave read data
- fill_o  out  NumPorts×$clog2(Depth+1)  FIFO occupancy per port

Behaviour:
- Ports are fully independent; there is no cross-port arbitration.
- Reset (`rst_i`=1, asynchronous):
  - FIFOs emptied; response pipes cleared.
  - `gnt_o`=0, `req_o`=0, `vld_o`=0, `rdata_o`=0, `fill_o`=0 while asserted.
  - Slave payload outputs `add_o`/`wen_o`/`wdata_o`/`be_o` read 0.
- Master grant: `gnt_o`[p] = `req_i`[p] & (`fill`[p] < Depth).
  - Never depends on `gnt_i` or on same-cycle pop.
  - When full, a push is refused even if a pop occurs in the same cycle.
- Push: on `req_i`&`gnt_o`, store {add, wen, wdata, be} at tail, except in the fall-through accept case below.
- Slave side, FIFO non-empty: `req_o`=1; payload = head entry. Pop on `req_o`&`gnt_i`.
- Slave side, FIFO empty:
  - FallThrough=0: `req_o`=0.
  - FallThrough=1: `req_o`=`req_i`, payload = inputs.
    - If `gnt_i`=1: the request completes and no push occurs.
    - If `gnt_i`=0: the request is pushed (`gnt_o`=1).
- Ordering: strict FIFO per port. A request must not bypass a non-empty FIFO.
- Simultaneous push+pop when not full: `fill` unchanged; the head advances and the new entry lands at the tail.
- Pointer wrap: modulo Depth, correct for non-power-of-two Depth.
- `fill_o` is registered; it reflects the accepted push/pop of the previous cycle.
- Response pipe per port: MemLatency-stage shift register of {valid, is_store}.
  - Stage 0 loads {`req_o`&`gnt_i`, `wen_o`}.
  - Tail stage T asserts `vld_o`[p] = T.valid & (~T.is_store | WriteRespEn).
  - `rdata_o`[p] = `vld_o`[p] ? `rdata_i`[p] : 0 (combinational pass).
  - Loads therefore return exactly MemLatency cycles after slave grant.
  - With Depth=1, FallThrough=0, master gnt→vld latency ≥ MemLatency+1.
- Back-to-back slave grants produce back-to-back `vld_o`; the response path never stalls.
- `rst_i` mid-operation: in-flight responses are dropped and queued requests discarded; after release the block behaves as freshly reset.
- Outputs of unused fields: `wdata_o`/`be_o` pass as stored for loads; no masking.

Test Plan:
- Reset hold: `rst_i`=1, `req_i`=all 1 → `gnt_o`=0, `req_o`=0, `vld_o`=0, `fill_o`=0. Release → `gnt_o`=`req_i` next cycle.
- Depth=2, `gnt_i`=0, port0 issues 3 loads 0x10, 0x14, 0x18 → first two granted, `fill_o`[0]=2, third held with `gnt_o`=0. `gnt_i`=1 → `add_o` sequence 0x10, 0x14, then 0x18 after re-grant.
- Full + pop same cycle (`fill`=2, `gnt_i`=1, `req_i`=1) → `gnt_o`=0 that cycle, `fill_o` drops to 1, grant returns next cycle.
- MemLatency=3, load granted at cycle t with `rdata_i`=0xDEADBEEF at t+3 → `vld_o`=1 and `rdata_o`=0xDEADBEEF exactly at t+3 only.
- WriteRespEn=0 vs 1, store granted → no `vld_o` vs single `vld_o` pulse at t+MemLatency.
- FallThrough=1, empty FIFO, `req_i`=1, `gnt_i`=1, add 0x40 → `req_o`=1 with `add_o`=0x40 same cycle, `fill_o` stays 0. Repeat with `gnt_i`=0 → push, `fill_o`=1. Mid-burst `rst_i` pulse → all queues and `vld_o` cleared.

Source files
------------

// File: rtl/tcdm_port_cut.sv
// Multi-port elastic TCDM request cut: one request FIFO and one fixed-latency
// response pipe per port, with optional fall-through and store responses.
module tcdm_port_cut #(
  parameter int unsigned NumPorts    = 4,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned Depth       = 2,
  parameter int unsigned MemLatency  = 1,
  parameter bit          WriteRespEn = 1'b0,
  parameter bit          FallThrough = 1'b0
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NumPorts-1:0]                     req_i,
  input  logic [NumPorts*AddrWidth-1:0]           add_i,
  input  logic [NumPorts-1:0]                     wen_i,
  input  logic [NumPorts*DataWidth-1:0]           wdata_i,
  input  logic [NumPorts*(DataWidth/8)-1:0]       be_i,
  output logic [NumPorts-1:0]                     gnt_o,
  output logic [NumPorts-1:0]                     vld_o,
  output logic [NumPorts*DataWidth-1:0]           rdata_o,
  output logic [NumPorts-1:0]                     req_o,
  input  logic [NumPorts-1:0]                     gnt_i,
  output logic [NumPorts*AddrWidth-1:0]           add_o,
  output logic [NumPorts-1:0]                     wen_o,
  output logic [NumPorts*DataWidth-1:0]           wdata_o,
  output logic [NumPorts*(DataWidth/8)-1:0]       be_o,
  input  logic [NumPorts*DataWidth-1:0]           rdata_i,
  output logic [NumPorts*$clog2(Depth+1)-1:0]     fill_o
);

  localparam int BeWidth = DataWidth / 8;
  localparam int FillW   = $clog2(Depth + 1);
  localparam int PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int EntryW  = AddrWidth + 1 + DataWidth + BeWidth;

  typedef struct packed {
    logic [AddrWidth-1:0] add;
    logic                 wen;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
  } entry_t;

  // Wraps modulo Depth so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(Depth - 1)) begin
      return {PtrW{1'b0}};
    end else begin
      return ptr + PtrW'(1);
    end
  endfunction

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    entry_t                r_mem [Depth];
    logic [PtrW-1:0]       r_head;
    logic [PtrW-1:0]       r_tail;
    logic [FillW-1:0]      r_fill;
    logic [MemLatency-1:0] r_pv;
    logic [MemLatency-1:0] r_ps;

    entry_t w_in;
    entry_t w_out;
    logic   w_empty;
    logic   w_full;
    logic   w_gnt;
    logic   w_ft;
    logic   w_req;
    logic   w_pop;
    logic   w_push;
    logic   w_vld;

    assign w_in.add   = add_i[p*AddrWidth +: AddrWidth];
    assign w_in.wen   = wen_i[p];
    assign w_in.wdata = wdata_i[p*DataWidth +: DataWidth];
    assign w_in.be    = be_i[p*BeWidth +: BeWidth];

    assign w_empty = (r_fill == {FillW{1'b0}});
    assign w_full  = (r_fill == FillW'(Depth));

    // Grant looks only at local occupancy, so a full FIFO refuses even when popping.
    assign w_gnt  = ~rst_i & req_i[p] & ~w_full;
    assign w_ft   = FallThrough & ~rst_i & w_empty & req_i[p];
    assign w_req  = ~rst_i & (~w_empty | w_ft);
    assign w_pop  = ~w_empty & gnt_i[p];
    assign w_push = w_gnt & ~(w_ft & gnt_i[p]);

    // Slave payload: head entry, or the live inputs when falling through.
    always_comb begin
      w_out = {EntryW{1'b0}};
      if (rst_i) begin
        w_out = {EntryW{1'b0}};
      end else if (!w_empty) begin
        w_out = r_mem[r_head];
      end else if (FallThrough) begin
        w_out = w_in;
      end else begin
        w_out = {EntryW{1'b0}};
      end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < Depth; i++) begin
          r_mem[i] <= {EntryW{1'b0}};
        end
        r_head <= {PtrW{1'b0}};
        r_tail <= {PtrW{1'b0}};
        r_fill <= {FillW{1'b0}};
      end else begin
        if (w_push) begin
          r_mem[r_tail] <= w_in;
          r_tail        <= next_ptr(r_tail);
        end
        if (w_pop) begin
          r_head <= next_ptr(r_head);
        end
        r_fill <= r_fill + FillW'(w_push) - FillW'(w_pop);
      end
    end

    // Response pipe of {valid, is_store}; never stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_pv <= {MemLatency{1'b0}};
        r_ps <= {MemLatency{1'b0}};
      end else begin
        r_pv[0] <= w_req & gnt_i[p];
        r_ps[0] <= w_out.wen;
        for (int i = 1; i < MemLatency; i++) begin
          r_pv[i] <= r_pv[i-1];
          r_ps[i] <= r_ps[i-1];
        end
      end
    end

    assign w_vld = r_pv[MemLatency-1] & (~r_ps[MemLatency-1] | WriteRespEn);

    assign gnt_o[p]                         = w_gnt;
    assign req_o[p]                         = w_req;
    assign add_o[p*AddrWidth +: AddrWidth]  = w_out.add;
    assign wen_o[p]                         = w_out.wen;
    assign wdata_o[p*DataWidth +: DataWidth] = w_out.wdata;
    assign be_o[p*BeWidth +: BeWidth]       = w_out.be;
    assign vld_o[p]                         = w_vld;
    assign rdata_o[p*DataWidth +: DataWidth] =
      w_vld ? rdata_i[p*DataWidth +: DataWidth] : {DataWidth{1'b0}};
    assign fill_o[p*FillW +: FillW]         = r_fill;
  end

endmodule

// File: tb/tb_tcdm_port_cut.sv
// Directed bench: instance A (Depth 2, latency 1, plain) and instance B
// (Depth 2, latency 3, store responses, fall-through), two ports each.
module tb_tcdm_port_cut;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [NP-1:0] a_req, a_wen, a_gnt_i, a_gnt_o, a_vld_o, a_req_o, a_wen_o;
  logic [NP*AW-1:0] a_add, a_add_o;
  logic [NP*DW-1:0] a_wdata, a_wdata_o, a_rdata_i, a_rdata_o;
  logic [NP*BW-1:0] a_be, a_be_o;
  logic [NP*FW-1:0] a_fill_o;

  logic [NP-1:0] b_req, b_wen, b_gnt_i, b_gnt_o, b_vld_o, b_req_o, b_wen_o;
  logic [NP*AW-1:0] b_add, b_add_o;
  logic [NP*DW-1:0] b_wdata, b_wdata_o, b_rdata_i, b_rdata_o;
  logic [NP*BW-1:0] b_be, b_be_o;
  logic [NP*FW-1:0] b_fill_o;

  tcdm_port_cut #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .Depth(2),
                  .MemLatency(1), .WriteRespEn(1'b0), .FallThrough(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .add_i(a_add), .wen_i(a_wen),
    .wdata_i(a_wdata), .be_i(a_be), .gnt_o(a_gnt_o), .vld_o(a_vld_o),
    .rdata_o(a_rdata_o), .req_o(a_req_o), .gnt_i(a_gnt_i), .add_o(a_add_o),
    .wen_o(a_wen_o), .wdata_o(a_wdata_o), .be_o(a_be_o), .rdata_i(a_rdata_i),
    .fill_o(a_fill_o));

  tcdm_port_cut #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .Depth(2),
                  .MemLatency(3), .WriteRespEn(1'b1), .FallThrough(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .add_i(b_add), .wen_i(b_wen),
    .wdata_i(b_wdata), .be_i(b_be), .gnt_o(b_gnt_o), .vld_o(b_vld_o),
    .rdata_o(b_rdata_o), .req_o(b_req_o), .gnt_i(b_gnt_i), .add_o(b_add_o),
    .wen_o(b_wen_o), .wdata_o(b_wdata_o), .be_o(b_be_o), .rdata_i(b_rdata_i),
    .fill_o(b_fill_o));

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    a_req = 2'b11; b_req = 2'b11; b_gnt_i = 2'b11; b_add = {32'h0, 32'h40};
    #1;
    checks++; if (a_gnt_o !== 2'b00) $display("FAIL rst_gnt: got %b want 00", a_gnt_o); else passed++;
    checks++; if (a_req_o !== 2'b00) $display("FAIL rst_req_o: got %b want 00", a_req_o); else passed++;
    checks++; if (b_req_o !== 2'b00) $display("FAIL rst_ft_req_o: got %b want 00", b_req_o); else passed++;
    checks++; if (b_add_o !== 64'h0) $display("FAIL rst_add_o: got %h want 0", b_add_o); else passed++;
    checks++; if (a_vld_o !== 2'b00 || a_fill_o !== 4'h0) $display("FAIL rst_vld_fill: got %b/%h want 00/0", a_vld_o, a_fill_o); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (a_gnt_o !== 2'b11) $display("FAIL rel_gnt: got %b want 11", a_gnt_o); else passed++;
    a_req = 2'b00; b_req = 2'b00; b_gnt_i = 2'b00; b_add = 64'h0;
  endtask

  task automatic test_fifo_order();
    a_gnt_i = 2'b00; a_req[0] = 1'b1; a_wen[0] = 1'b0; a_add[31:0] = 32'h10;
    #1;
    checks++; if (a_gnt_o[0] !== 1'b1) $display("FAIL f_gnt0: got %b want 1", a_gnt_o[0]); else passed++;
    step(); a_add[31:0] = 32'h14; #1;
    checks++; if (a_fill_o[1:0] !== 2'd1) $display("FAIL f_fill1: got %0d want 1", a_fill_o[1:0]); else passed++;
    checks++; if (a_req_o[0] !== 1'b1 || a_add_o[31:0] !== 32'h10) $display("FAIL f_head10: got %b/%h want 1/10", a_req_o[0], a_add_o[31:0]); else passed++;
    step(); a_add[31:0] = 32'h18; #1;
    checks++; if (a_fill_o[1:0] !== 2'd2) $display("FAIL f_fill2: got %0d want 2", a_fill_o[1:0]); else passed++;
    checks++; if (a_gnt_o[0] !== 1'b0) $display("FAIL f_full_gnt: got %b want 0", a_gnt_o[0]); else passed++;
    step(); a_gnt_i[0] = 1'b1; #1;
    checks++; if (a_gnt_o[0] !== 1'b0) $display("FAIL f_full_pop_gnt: got %b want 0", a_gnt_o[0]); else passed++;
    checks++; if (a_add_o[31:0] !== 32'h10) $display("FAIL f_pop10: got %h want 10", a_add_o[31:0]); else passed++;
    step(); a_rdata_i[31:0] = 32'hDEADBEEF; #1;
    checks++; if (a_fill_o[1:0] !== 2'd1) $display("FAIL f_fill_drop: got %0d want 1", a_fill_o[1:0]); else passed++;
    checks++; if (a_gnt_o[0] !== 1'b1) $display("FAIL f_gnt_back: got %b want 1", a_gnt_o[0]); else passed++;
    checks++; if (a_add_o[31:0] !== 32'h14) $display("FAIL f_pop14: got %h want 14", a_add_o[31:0]); else passed++;
    checks++; if (a_vld_o[0] !== 1'b1 || a_rdata_o[31:0] !== 32'hDEADBEEF) $display("FAIL f_rsp10: got %b/%h want 1/deadbeef", a_vld_o[0], a_rdata_o[31:0]); else passed++;
    step(); #1;
    checks++; if (a_fill_o[1:0] !== 2'd1 || a_add_o[31:0] !== 32'h18) $display("FAIL f_pushpop: got %0d/%h want 1/18", a_fill_o[1:0], a_add_o[31:0]); else passed++;
    checks++; if (a_vld_o[0] !== 1'b1) $display("FAIL f_rsp14: got %b want 1", a_vld_o[0]); else passed++;
    a_req[0] = 1'b0;
    step(); #1;
    checks++; if (a_fill_o[1:0] !== 2'd0 || a_req_o[0] !== 1'b0) $display("FAIL f_empty: got %0d/%b want 0/0", a_fill_o[1:0], a_req_o[0]); else passed++;
    checks++; if (a_vld_o[0] !== 1'b1) $display("FAIL f_rsp18: got %b want 1", a_vld_o[0]); else passed++;
    checks++; if (a_req_o[1] !== 1'b0 || a_fill_o[3:2] !== 2'd0) $display("FAIL f_port1_idle: got %b/%0d want 0/0", a_req_o[1], a_fill_o[3:2]); else passed++;
    a_gnt_i[0] = 1'b0;
    step(); #1;
    checks++; if (a_vld_o[0] !== 1'b0 || a_rdata_o[31:0] !== 32'h0) $display("FAIL f_rdata_mask: got %b/%h want 0/0", a_vld_o[0], a_rdata_o[31:0]); else passed++;
  endtask

  task automatic test_store_no_resp();
    a_req[1] = 1'b1; a_wen[1] = 1'b1; a_add[63:32] = 32'h80;
    a_wdata[63:32] = 32'hCAFE0001; a_be[7:4] = 4'hA; a_gnt_i[1] = 1'b1;
    step(); a_req[1] = 1'b0; #1;
    checks++; if (a_req_o[1] !== 1'b1 || a_wen_o[1] !== 1'b1 || a_add_o[63:32] !== 32'h80) $display("FAIL s_payload: got %b/%b/%h want 1/1/80", a_req_o[1], a_wen_o[1], a_add_o[63:32]); else passed++;
    checks++; if (a_wdata_o[63:32] !== 32'hCAFE0001 || a_be_o[7:4] !== 4'hA) $display("FAIL s_wdata_be: got %h/%h want cafe0001/a", a_wdata_o[63:32], a_be_o[7:4]); else passed++;
    step(); #1;
    checks++; if (a_vld_o[1] !== 1'b0) $display("FAIL s_no_vld: got %b want 0", a_vld_o[1]); else passed++;
    a_gnt_i[1] = 1'b0; a_wen[1] = 1'b0;
  endtask

  task automatic test_latency();
    b_req[0] = 1'b1; b_wen[0] = 1'b0; b_add[31:0] = 32'h40; b_gnt_i[0] = 1'b1;
    #1;
    checks++; if (b_req_o[0] !== 1'b1 || b_add_o[31:0] !== 32'h40) $display("FAIL ft_pass: got %b/%h want 1/40", b_req_o[0], b_add_o[31:0]); else passed++;
    step(); b_req[0] = 1'b0; b_gnt_i[0] = 1'b0; b_rdata_i[31:0] = 32'hDEADBEEF; #1;
    checks++; if (b_fill_o[1:0] !== 2'd0) $display("FAIL ft_nofill: got %0d want 0", b_fill_o[1:0]); else passed++;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (b_vld_o[0] !== (k == 3) || b_rdata_o[31:0] !== ((k == 3) ? 32'hDEADBEEF : 32'h0))
        $display("FAIL lat_t%0d: got %b/%h want %b", k, b_vld_o[0], b_rdata_o[31:0], (k == 3)); else passed++;
      step(); #1;
    end
  endtask

  task automatic test_write_resp();
    b_req[1] = 1'b1; b_wen[1] = 1'b1; b_add[63:32] = 32'h50; b_gnt_i[1] = 1'b1;
    step(); b_req[1] = 1'b0; b_gnt_i[1] = 1'b0; #1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (b_vld_o[1] !== (k == 3)) $display("FAIL wr_t%0d: got %b want %b", k, b_vld_o[1], (k == 3)); else passed++;
      step(); #1;
    end
    b_wen[1] = 1'b0;
  endtask

  task automatic test_ft_push_and_reset();
    b_req[0] = 1'b1; b_add[31:0] = 32'h44; b_gnt_i[0] = 1'b0;
    #1;
    checks++; if (b_req_o[0] !== 1'b1 || b_gnt_o[0] !== 1'b1 || b_add_o[31:0] !== 32'h44) $display("FAIL ftp_req: got %b/%b/%h want 1/1/44", b_req_o[0], b_gnt_o[0], b_add_o[31:0]); else passed++;
    step(); b_add[31:0] = 32'h48; #1;
    checks++; if (b_fill_o[1:0] !== 2'd1) $display("FAIL ftp_fill1: got %0d want 1", b_fill_o[1:0]); else passed++;
    checks++; if (b_add_o[31:0] !== 32'h44) $display("FAIL ftp_nobypass: got %h want 44", b_add_o[31:0]); else passed++;
    step(); b_req[0] = 1'b0; b_req[1] = 1'b1; b_add[63:32] = 32'h60; b_gnt_i[1] = 1'b1; #1;
    checks++; if (b_fill_o[1:0] !== 2'd2) $display("FAIL ftp_fill2: got %0d want 2", b_fill_o[1:0]); else passed++;
    step(); b_req[1] = 1'b0; b_gnt_i[1] = 1'b0; rst = 1'b1; #1;
    checks++; if (b_fill_o !== 4'h0 || b_req_o !== 2'b00 || b_vld_o !== 2'b00) $display("FAIL mrst_clear: got %h/%b/%b want 0/00/00", b_fill_o, b_req_o, b_vld_o); else passed++;
    checks++; if (b_add_o !== 64'h0) $display("FAIL mrst_add: got %h want 0", b_add_o); else passed++;
    step(); rst = 1'b0; #1;
    for (int k = 1; k <= 3; k++) begin
      checks++; if (b_vld_o !== 2'b00 || b_req_o !== 2'b00 || b_fill_o !== 4'h0) $display("FAIL mrst_after%0d: got %b/%b/%h want 00/00/0", k, b_vld_o, b_req_o, b_fill_o); else passed++;
      step(); #1;
    end
  endtask

  initial begin
    a_req = '0; a_wen = '0; a_gnt_i = '0; a_add = '0; a_wdata = '0; a_be = '0; a_rdata_i = '0;
    b_req = '0; b_wen = '0; b_gnt_i = '0; b_add = '0; b_wdata = '0; b_be = '0; b_rdata_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    step();
    test_fifo_order();
    test_store_no_resp();
    test_latency();
    test_write_resp();
    test_ft_push_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
